// File: rtl/response_memory_pool_if.sv
// R-channel handshake bundle between the fabric, the per-UID beat store and the
// R ordering unit. The master side drives incoming beats and selects the UID to drain.
interface response_memory_pool_if #(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 64,
  parameter int RESP_WIDTH = 2
);
  logic                  r_in_valid;
  logic                  r_in_ready;
  logic [ID_WIDTH-1:0]   r_in_id;
  logic [DATA_WIDTH-1:0] r_in_data;
  logic [RESP_WIDTH-1:0] r_in_resp;
  logic                  r_in_last;
  logic [ID_WIDTH-1:0]   uid_to_free;
  logic                  r_out_valid;
  logic                  r_out_ready;
  logic [ID_WIDTH-1:0]   r_out_id;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [RESP_WIDTH-1:0] r_out_resp;
  logic                  r_out_last;

  modport master (
    output r_in_valid, r_in_id, r_in_data, r_in_resp, r_in_last, uid_to_free, r_out_ready,
    input  r_in_ready, r_out_valid, r_out_id, r_out_data, r_out_resp, r_out_last
  );

  modport slave (
    input  r_in_valid, r_in_id, r_in_data, r_in_resp, r_in_last, uid_to_free, r_out_ready,
    output r_in_ready, r_out_valid, r_out_id, r_out_data, r_out_resp, r_out_last
  );
endinterface

// File: rtl/response_memory_pool.sv
// Per-UID circular R-beat store with optional store-and-forward gating, per-UID flush,
// sticky store-and-forward deadlock flags and a running occupancy counter.
module response_memory_pool #(
  parameter int NUM_UIDS   = 16,
  parameter int MAX_BEATS  = 8,
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 64,
  parameter int RESP_WIDTH = 2,
  parameter int STORE_FWD  = 0,
  parameter int TOT_W      = $clog2(NUM_UIDS*MAX_BEATS+1)
) (
  input  logic                clk,
  input  logic                rst_n,
  response_memory_pool_if.slave bus,
  input  logic                flush_valid,
  input  logic [ID_WIDTH-1:0] flush_uid,
  output logic [NUM_UIDS-1:0] uid_nonempty,
  output logic [NUM_UIDS-1:0] uid_burst_ready,
  output logic [NUM_UIDS-1:0] deadlock_err,
  output logic [TOT_W-1:0]    total_beats
);

  localparam int PTR_W = $clog2(MAX_BEATS);
  localparam int CNT_W = $clog2(MAX_BEATS+1);
  localparam int MEM_W = DATA_WIDTH + RESP_WIDTH + 1;
  localparam logic [CNT_W-1:0] FULL      = CNT_W'(MAX_BEATS);
  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(MAX_BEATS-1);

  logic [MEM_W-1:0] mem [NUM_UIDS][MAX_BEATS];

  logic [PTR_W-1:0] wptr      [NUM_UIDS];
  logic [PTR_W-1:0] rptr      [NUM_UIDS];
  logic [CNT_W-1:0] count     [NUM_UIDS];
  logic [CNT_W-1:0] bursts    [NUM_UIDS];
  logic [PTR_W-1:0] wptr_nxt  [NUM_UIDS];
  logic [PTR_W-1:0] rptr_nxt  [NUM_UIDS];
  logic [CNT_W-1:0] count_nxt [NUM_UIDS];
  logic [CNT_W-1:0] bursts_nxt[NUM_UIDS];
  logic [NUM_UIDS-1:0] deadlock_nxt;
  logic [NUM_UIDS-1:0] wr_sel;
  logic [NUM_UIDS-1:0] rd_sel;
  logic [NUM_UIDS-1:0] fl_sel;
  logic [TOT_W-1:0]    total_nxt;
  logic [TOT_W-1:0]    flush_cnt;

  logic                in_range;
  logic                out_range;
  logic                flush_range;
  logic [ID_WIDTH-1:0] in_idx;
  logic [ID_WIDTH-1:0] out_idx;
  logic [ID_WIDTH-1:0] flush_idx;
  logic                in_flush;
  logic                out_flush;
  logic                accept;
  logic                pop;
  logic [MEM_W-1:0]    head;
  logic                head_last;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + 1'b1;
  endfunction

  // UIDs beyond NUM_UIDS look permanently full and empty; their index is parked at 0.
  assign in_range    = int'(bus.r_in_id) < NUM_UIDS;
  assign out_range   = int'(bus.uid_to_free) < NUM_UIDS;
  assign flush_range = int'(flush_uid) < NUM_UIDS;
  assign in_idx      = in_range ? bus.r_in_id : '0;
  assign out_idx     = out_range ? bus.uid_to_free : '0;
  assign flush_idx   = flush_range ? flush_uid : '0;
  assign in_flush    = flush_valid && (flush_uid == bus.r_in_id);
  assign out_flush   = flush_valid && (flush_uid == bus.uid_to_free);

  assign bus.r_in_ready  = rst_n && in_range && (count[in_idx] != FULL) && !in_flush;
  assign bus.r_out_valid = rst_n && out_range && (count[out_idx] != '0) &&
                           ((STORE_FWD == 0) || (bursts[out_idx] != '0)) && !out_flush;

  assign accept    = bus.r_in_valid && bus.r_in_ready;
  assign pop       = bus.r_out_valid && bus.r_out_ready;
  assign head      = mem[out_idx][rptr[out_idx]];
  assign head_last = head[MEM_W-1];

  assign bus.r_out_id   = bus.uid_to_free;
  assign bus.r_out_last = bus.r_out_valid ? head_last : 1'b0;
  assign bus.r_out_resp = bus.r_out_valid ? head[DATA_WIDTH +: RESP_WIDTH] : '0;
  assign bus.r_out_data = bus.r_out_valid ? head[DATA_WIDTH-1:0] : '0;

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[in_idx][wptr[in_idx]] <= {bus.r_in_last, bus.r_in_resp, bus.r_in_data};
    end
  end

  // Flush takes priority over every other update of its UID, including deadlock setting.
  always_comb begin
    wr_sel       = '0;
    rd_sel       = '0;
    fl_sel       = '0;
    deadlock_nxt = deadlock_err;
    for (int u = 0; u < NUM_UIDS; u++) begin
      wr_sel[u]     = accept && (in_idx == ID_WIDTH'(u));
      rd_sel[u]     = pop && (out_idx == ID_WIDTH'(u));
      fl_sel[u]     = flush_valid && flush_range && (flush_idx == ID_WIDTH'(u));
      wptr_nxt[u]   = wr_sel[u] ? ptr_inc(wptr[u]) : wptr[u];
      rptr_nxt[u]   = rd_sel[u] ? ptr_inc(rptr[u]) : rptr[u];
      count_nxt[u]  = count[u] + CNT_W'(wr_sel[u]) - CNT_W'(rd_sel[u]);
      bursts_nxt[u] = bursts[u] + CNT_W'(wr_sel[u] && bus.r_in_last)
                                - CNT_W'(rd_sel[u] && head_last);
      if ((STORE_FWD != 0) && bus.r_in_valid && in_range && (in_idx == ID_WIDTH'(u)) &&
          (count[u] == FULL) && (bursts[u] == '0)) begin
        deadlock_nxt[u] = 1'b1;
      end
      if (fl_sel[u]) begin
        wptr_nxt[u]     = '0;
        rptr_nxt[u]     = '0;
        count_nxt[u]    = '0;
        bursts_nxt[u]   = '0;
        deadlock_nxt[u] = 1'b0;
      end
    end
    flush_cnt = (flush_valid && flush_range) ? TOT_W'(count[flush_idx]) : '0;
    total_nxt = total_beats + TOT_W'(accept) - TOT_W'(pop) - flush_cnt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int u = 0; u < NUM_UIDS; u++) begin
        wptr[u]   <= '0;
        rptr[u]   <= '0;
        count[u]  <= '0;
        bursts[u] <= '0;
      end
      deadlock_err <= '0;
      total_beats  <= '0;
    end else begin
      for (int u = 0; u < NUM_UIDS; u++) begin
        wptr[u]   <= wptr_nxt[u];
        rptr[u]   <= rptr_nxt[u];
        count[u]  <= count_nxt[u];
        bursts[u] <= bursts_nxt[u];
      end
      deadlock_err <= deadlock_nxt;
      total_beats  <= total_nxt;
    end
  end

  always_comb begin
    uid_nonempty    = '0;
    uid_burst_ready = '0;
    for (int u = 0; u < NUM_UIDS; u++) begin
      uid_nonempty[u]    = (count[u] != '0);
      uid_burst_ready[u] = (bursts[u] != '0);
    end
  end

endmodule

// File: tb/tb_response_memory_pool.sv
// Directed bench for response_memory_pool: one cut-through instance and one
// store-and-forward instance, each scenario checked against hand-computed values.
module tb_response_memory_pool;

  logic        clk;
  logic        rst_n;
  logic        flush_valid0, flush_valid1;
  logic [3:0]  flush_uid0, flush_uid1;
  logic [15:0] nonempty0, nonempty1, burst_ready0, burst_ready1, deadlock0, deadlock1;
  logic [7:0]  total0, total1;
  int          checks;
  int          errors;
  logic [63:0] exp_d;

  response_memory_pool_if #(.ID_WIDTH(4), .DATA_WIDTH(64), .RESP_WIDTH(2)) if0 ();
  response_memory_pool_if #(.ID_WIDTH(4), .DATA_WIDTH(64), .RESP_WIDTH(2)) if1 ();

  response_memory_pool #(.NUM_UIDS(16), .MAX_BEATS(8), .ID_WIDTH(4), .DATA_WIDTH(64),
                         .RESP_WIDTH(2), .STORE_FWD(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave), .flush_valid(flush_valid0), .flush_uid(flush_uid0),
    .uid_nonempty(nonempty0), .uid_burst_ready(burst_ready0), .deadlock_err(deadlock0),
    .total_beats(total0));

  response_memory_pool #(.NUM_UIDS(16), .MAX_BEATS(8), .ID_WIDTH(4), .DATA_WIDTH(64),
                         .RESP_WIDTH(2), .STORE_FWD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave), .flush_valid(flush_valid1), .flush_uid(flush_uid1),
    .uid_nonempty(nonempty1), .uid_burst_ready(burst_ready1), .deadlock_err(deadlock1),
    .total_beats(total1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Resp rides on the low data bits so every beat carries a distinct, checkable resp.
  task automatic drive0(input logic v, input logic [3:0] id, input logic [63:0] d,
                        input logic l, input logic [3:0] uf, input logic ordy);
    if0.r_in_valid = v; if0.r_in_id = id; if0.r_in_data = d; if0.r_in_resp = d[1:0];
    if0.r_in_last = l; if0.uid_to_free = uf; if0.r_out_ready = ordy;
  endtask

  task automatic drive1(input logic v, input logic [3:0] id, input logic [63:0] d,
                        input logic l, input logic [3:0] uf, input logic ordy);
    if1.r_in_valid = v; if1.r_in_id = id; if1.r_in_data = d; if1.r_in_resp = d[1:0];
    if1.r_in_last = l; if1.uid_to_free = uf; if1.r_out_ready = ordy;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    flush_valid0 = 1'b0; flush_uid0 = 4'd0; flush_valid1 = 1'b0; flush_uid1 = 4'd0;
    drive0(1'b1, 4'd3, 64'h0, 1'b0, 4'd3, 1'b1);
    drive1(1'b0, 4'd0, 64'h0, 1'b0, 4'd0, 1'b0);
    @(negedge clk); #1;
    checks++; if (if0.r_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_in_ready_low: got %0b want 0", if0.r_in_ready); end
    checks++; if (if0.r_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid_low: got %0b want 0", if0.r_out_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    drive0(1'b0, 4'd0, 64'h0, 1'b0, 4'd0, 1'b0);
    #1;
    checks++; if (total0 !== 8'd0) begin errors++; $display("[TB] FAIL rst_total: got %0d want 0", total0); end
    checks++; if (nonempty0 !== 16'h0) begin errors++; $display("[TB] FAIL rst_nonempty: got %0h want 0", nonempty0); end
    checks++; if (deadlock0 !== 16'h0) begin errors++; $display("[TB] FAIL rst_deadlock: got %0h want 0", deadlock0); end
    checks++; if (if0.r_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_in_ready_rel: got %0b want 1", if0.r_in_ready); end
    checks++; if (if0.r_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid_rel: got %0b want 0", if0.r_out_valid); end
    checks++; if (if0.r_out_data !== 64'h0) begin errors++; $display("[TB] FAIL rst_out_data: got %0h want 0", if0.r_out_data); end
  endtask

  task automatic test_cut_through;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      drive0(i < 4, 4'd3, 64'hA0 + 64'(i), i == 3, 4'd3, 1'b1);
      #1;
      checks++; if (if0.r_out_valid !== (i > 0)) begin errors++; $display("[TB] FAIL ct_valid[%0d]: got %0b want %0b", i, if0.r_out_valid, i > 0); end
      if (i > 0) begin
        exp_d = 64'hA0 + 64'(i - 1);
        checks++; if (if0.r_out_data !== exp_d) begin errors++; $display("[TB] FAIL ct_data[%0d]: got %0h want %0h", i, if0.r_out_data, exp_d); end
        checks++; if (if0.r_out_resp !== exp_d[1:0]) begin errors++; $display("[TB] FAIL ct_resp[%0d]: got %0h want %0h", i, if0.r_out_resp, exp_d[1:0]); end
        checks++; if (if0.r_out_last !== (i == 4)) begin errors++; $display("[TB] FAIL ct_last[%0d]: got %0b want %0b", i, if0.r_out_last, i == 4); end
        checks++; if (if0.r_out_id !== 4'd3) begin errors++; $display("[TB] FAIL ct_id[%0d]: got %0d want 3", i, if0.r_out_id); end
      end
    end
    @(negedge clk);
    drive0(1'b0, 4'd3, 64'h0, 1'b0, 4'd3, 1'b0);
    #1;
    checks++; if (if0.r_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL ct_drained_valid: got %0b want 0", if0.r_out_valid); end
    checks++; if (nonempty0[3] !== 1'b0) begin errors++; $display("[TB] FAIL ct_nonempty3: got %0b want 0", nonempty0[3]); end
    checks++; if (total0 !== 8'd0) begin errors++; $display("[TB] FAIL ct_total: got %0d want 0", total0); end
  endtask

  task automatic test_full_wrap;
    logic [63:0] next_out;
    logic [63:0] next_in;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive0(1'b1, 4'd5, 64'h500 + 64'(i), 1'b0, 4'd5, 1'b0);
      #1;
      checks++; if (if0.r_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL fw_fill_ready[%0d]: got %0b want 1", i, if0.r_in_ready); end
    end
    @(negedge clk);
    drive0(1'b0, 4'd5, 64'h0, 1'b0, 4'd5, 1'b0);
    #1;
    checks++; if (if0.r_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL fw_full_id5: got %0b want 0", if0.r_in_ready); end
    drive0(1'b0, 4'd6, 64'h0, 1'b0, 4'd5, 1'b0);
    #1;
    checks++; if (if0.r_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL fw_id6_ready: got %0b want 1", if0.r_in_ready); end
    drive0(1'b1, 4'd5, 64'h508, 1'b0, 4'd5, 1'b1);
    #1;
    checks++; if (if0.r_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL fw_no_bypass: got %0b want 0", if0.r_in_ready); end
    checks++; if (if0.r_out_data !== 64'h500) begin errors++; $display("[TB] FAIL fw_pop_head: got %0h want 500", if0.r_out_data); end
    @(negedge clk);
    drive0(1'b1, 4'd5, 64'h508, 1'b0, 4'd5, 1'b0);
    #1;
    checks++; if (if0.r_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL fw_after_pop_ready: got %0b want 1", if0.r_in_ready); end
    checks++; if (deadlock0 !== 16'h0) begin errors++; $display("[TB] FAIL fw_no_deadlock_cut: got %0h want 0", deadlock0); end
    next_out = 64'h501;
    next_in  = 64'h509;
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        drive0(1'b0, 4'd5, 64'h0, 1'b0, 4'd5, 1'b1);
        #1;
        checks++; if (if0.r_out_data !== next_out) begin errors++; $display("[TB] FAIL fw_drain_data: got %0h want %0h", if0.r_out_data, next_out); end
        next_out = next_out + 64'd1;
      end
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        drive0(1'b1, 4'd5, next_in, 1'b0, 4'd5, 1'b0);
        #1;
        checks++; if (if0.r_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL fw_refill_ready: got %0b want 1", if0.r_in_ready); end
        next_in = next_in + 64'd1;
      end
    end
    @(negedge clk);
    drive0(1'b0, 4'd5, 64'h0, 1'b0, 4'd5, 1'b0);
    #1;
    checks++; if (total0 !== 8'd8) begin errors++; $display("[TB] FAIL fw_total: got %0d want 8", total0); end
    checks++; if (if0.r_out_data !== next_out) begin errors++; $display("[TB] FAIL fw_final_head: got %0h want %0h", if0.r_out_data, next_out); end
    @(negedge clk);
    flush_valid0 = 1'b1; flush_uid0 = 4'd5;
    #1;
    checks++; if (if0.r_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL fw_flush_blocks_pop: got %0b want 0", if0.r_out_valid); end
    @(negedge clk);
    flush_valid0 = 1'b0;
    #1;
    checks++; if (total0 !== 8'd0) begin errors++; $display("[TB] FAIL fw_flush_total: got %0d want 0", total0); end
    checks++; if (nonempty0[5] !== 1'b0) begin errors++; $display("[TB] FAIL fw_flush_nonempty5: got %0b want 0", nonempty0[5]); end
  endtask

  task automatic test_simultaneous;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive0(1'b1, 4'd7, 64'h70 + 64'(i), 1'b0, 4'd7, 1'b0);
    end
    @(negedge clk);
    drive0(1'b1, 4'd7, 64'h73, 1'b0, 4'd7, 1'b1);
    #1;
    checks++; if (total0 !== 8'd3) begin errors++; $display("[TB] FAIL sim_total_before: got %0d want 3", total0); end
    checks++; if (if0.r_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL sim_ready: got %0b want 1", if0.r_in_ready); end
    checks++; if (if0.r_out_data !== 64'h70) begin errors++; $display("[TB] FAIL sim_head: got %0h want 70", if0.r_out_data); end
    @(negedge clk);
    drive0(1'b0, 4'd7, 64'h0, 1'b0, 4'd7, 1'b0);
    #1;
    checks++; if (total0 !== 8'd3) begin errors++; $display("[TB] FAIL sim_total_after: got %0d want 3", total0); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive0(1'b0, 4'd7, 64'h0, 1'b0, 4'd7, 1'b1);
      #1;
      exp_d = 64'h71 + 64'(i);
      checks++; if (if0.r_out_data !== exp_d) begin errors++; $display("[TB] FAIL sim_drain[%0d]: got %0h want %0h", i, if0.r_out_data, exp_d); end
    end
    @(negedge clk);
    drive0(1'b0, 4'd7, 64'h0, 1'b0, 4'd7, 1'b0);
    #1;
    checks++; if (nonempty0[7] !== 1'b0) begin errors++; $display("[TB] FAIL sim_nonempty7: got %0b want 0", nonempty0[7]); end
  endtask

  task automatic test_flush_concurrent;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive0(1'b1, 4'd4, 64'h40 + 64'(i), 1'b0, 4'd4, 1'b0);
    end
    @(negedge clk);
    flush_valid0 = 1'b1; flush_uid0 = 4'd4;
    drive0(1'b0, 4'd4, 64'h0, 1'b0, 4'd4, 1'b1);
    #1;
    checks++; if (if0.r_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL fl_block_write: got %0b want 0", if0.r_in_ready); end
    checks++; if (if0.r_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL fl_block_pop: got %0b want 0", if0.r_out_valid); end
    drive0(1'b1, 4'd9, 64'h90, 1'b0, 4'd4, 1'b1);
    #1;
    checks++; if (if0.r_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL fl_other_ready: got %0b want 1", if0.r_in_ready); end
    @(negedge clk);
    flush_valid0 = 1'b0;
    drive0(1'b0, 4'd9, 64'h0, 1'b0, 4'd4, 1'b0);
    #1;
    checks++; if (if0.r_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL fl_uid4_empty: got %0b want 0", if0.r_out_valid); end
    checks++; if (nonempty0 !== 16'h0200) begin errors++; $display("[TB] FAIL fl_nonempty: got %0h want 0200", nonempty0); end
    checks++; if (total0 !== 8'd1) begin errors++; $display("[TB] FAIL fl_total: got %0d want 1", total0); end
    @(negedge clk);
    drive0(1'b0, 4'd9, 64'h0, 1'b0, 4'd9, 1'b1);
    #1;
    checks++; if (if0.r_out_data !== 64'h90) begin errors++; $display("[TB] FAIL fl_uid9_data: got %0h want 90", if0.r_out_data); end
    @(negedge clk);
    drive0(1'b0, 4'd9, 64'h0, 1'b0, 4'd9, 1'b0);
    #1;
    checks++; if (total0 !== 8'd0) begin errors++; $display("[TB] FAIL fl_total_end: got %0d want 0", total0); end
  endtask

  task automatic test_store_fwd;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive1(1'b1, 4'd2, 64'h20 + 64'(i), i == 3, 4'd2, 1'b0);
      #1;
      checks++; if (if1.r_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL sf_hold[%0d]: got %0b want 0", i, if1.r_out_valid); end
    end
    @(negedge clk);
    drive1(1'b0, 4'd2, 64'h0, 1'b0, 4'd2, 1'b0);
    #1;
    checks++; if (if1.r_out_valid !== 1'b1) begin errors++; $display("[TB] FAIL sf_release: got %0b want 1", if1.r_out_valid); end
    checks++; if (burst_ready1[2] !== 1'b1) begin errors++; $display("[TB] FAIL sf_burst_ready: got %0b want 1", burst_ready1[2]); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive1(1'b0, 4'd2, 64'h0, 1'b0, 4'd2, 1'b1);
      #1;
      exp_d = 64'h20 + 64'(i);
      checks++; if (if1.r_out_data !== exp_d) begin errors++; $display("[TB] FAIL sf_data[%0d]: got %0h want %0h", i, if1.r_out_data, exp_d); end
      checks++; if (if1.r_out_last !== (i == 3)) begin errors++; $display("[TB] FAIL sf_last[%0d]: got %0b want %0b", i, if1.r_out_last, i == 3); end
    end
    @(negedge clk);
    drive1(1'b0, 4'd2, 64'h0, 1'b0, 4'd2, 1'b0);
    #1;
    checks++; if (burst_ready1[2] !== 1'b0) begin errors++; $display("[TB] FAIL sf_burst_clear: got %0b want 0", burst_ready1[2]); end
    checks++; if (nonempty1[2] !== 1'b0) begin errors++; $display("[TB] FAIL sf_nonempty2: got %0b want 0", nonempty1[2]); end
  endtask

  task automatic test_deadlock;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive1(1'b1, 4'd1, 64'h10 + 64'(i), 1'b0, 4'd1, 1'b0);
      #1;
      checks++; if (if1.r_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL dl_fill_ready[%0d]: got %0b want 1", i, if1.r_in_ready); end
    end
    @(negedge clk);
    drive1(1'b1, 4'd1, 64'h18, 1'b0, 4'd1, 1'b0);
    #1;
    checks++; if (if1.r_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL dl_full_ready: got %0b want 0", if1.r_in_ready); end
    checks++; if (deadlock1[1] !== 1'b0) begin errors++; $display("[TB] FAIL dl_not_yet: got %0b want 0", deadlock1[1]); end
    @(negedge clk);
    drive1(1'b0, 4'd1, 64'h0, 1'b0, 4'd1, 1'b1);
    #1;
    checks++; if (deadlock1[1] !== 1'b1) begin errors++; $display("[TB] FAIL dl_set: got %0b want 1", deadlock1[1]); end
    checks++; if (if1.r_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL dl_no_head: got %0b want 0", if1.r_out_valid); end
    checks++; if (total1 !== 8'd8) begin errors++; $display("[TB] FAIL dl_total: got %0d want 8", total1); end
    @(negedge clk);
    drive1(1'b0, 4'd1, 64'h0, 1'b0, 4'd1, 1'b0);
    #1;
    checks++; if (deadlock1[1] !== 1'b1) begin errors++; $display("[TB] FAIL dl_sticky: got %0b want 1", deadlock1[1]); end
    flush_valid1 = 1'b1; flush_uid1 = 4'd1;
    @(negedge clk);
    flush_valid1 = 1'b0;
    #1;
    checks++; if (deadlock1 !== 16'h0) begin errors++; $display("[TB] FAIL dl_flush_clear: got %0h want 0", deadlock1); end
    checks++; if (nonempty1[1] !== 1'b0) begin errors++; $display("[TB] FAIL dl_flush_nonempty: got %0b want 0", nonempty1[1]); end
    checks++; if (total1 !== 8'd0) begin errors++; $display("[TB] FAIL dl_flush_total: got %0d want 0", total1); end
    checks++; if (if1.r_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL dl_flush_ready: got %0b want 1", if1.r_in_ready); end
  endtask

  task automatic test_reset_midburst;
    logic [3:0] uid;
    for (int i = 0; i < 10; i++) begin
      uid = (i < 4) ? 4'd10 : ((i < 7) ? 4'd11 : 4'd12);
      @(negedge clk);
      drive0(1'b1, uid, 64'hC0 + 64'(i), 1'b0, 4'd10, 1'b0);
    end
    @(negedge clk);
    drive0(1'b0, 4'd13, 64'h0, 1'b0, 4'd10, 1'b0);
    #1;
    checks++; if (total0 !== 8'd10) begin errors++; $display("[TB] FAIL rm_total: got %0d want 10", total0); end
    checks++; if (nonempty0 !== 16'h1C00) begin errors++; $display("[TB] FAIL rm_nonempty: got %0h want 1c00", nonempty0); end
    checks++; if (if0.r_out_valid !== 1'b1) begin errors++; $display("[TB] FAIL rm_head_valid: got %0b want 1", if0.r_out_valid); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (if0.r_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rm_rst_ready: got %0b want 0", if0.r_in_ready); end
    checks++; if (if0.r_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rm_rst_valid: got %0b want 0", if0.r_out_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (total0 !== 8'd0) begin errors++; $display("[TB] FAIL rm_total_after: got %0d want 0", total0); end
    checks++; if (nonempty0 !== 16'h0) begin errors++; $display("[TB] FAIL rm_nonempty_after: got %0h want 0", nonempty0); end
    checks++; if (if0.r_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rm_ready_after: got %0b want 1", if0.r_in_ready); end
    checks++; if (if0.r_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rm_valid_after: got %0b want 0", if0.r_out_valid); end
    checks++; if (if0.r_out_data !== 64'h0) begin errors++; $display("[TB] FAIL rm_data_after: got %0h want 0", if0.r_out_data); end
    checks++; if (total1 !== 8'd0) begin errors++; $display("[TB] FAIL rm_total1_after: got %0d want 0", total1); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_cut_through();
    test_full_wrap();
    test_simultaneous();
    test_flush_concurrent();
    test_store_fwd();
    test_deadlock();
    test_reset_midburst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
